// File: rtl/gshare_pkg.sv
// Shared types and constants for the gshare pattern history table.
package gshare_pkg;

  localparam int PHT_IDX_W = 10;

  typedef logic [1:0] pht_cnt_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } pht_state_e;

  localparam pht_cnt_t PHT_WNT = 2'b01;

endpackage

// File: rtl/gshare_pht_sat_cnt2.sv
// 2-bit saturating counter next-value logic (purely combinational).
module sat_cnt2
  import gshare_pkg::*;
(
  input  pht_cnt_t cnt,
  input  logic     taken,
  output pht_cnt_t cnt_nxt
);

  always_comb begin
    cnt_nxt = cnt;
    if (taken) begin
      if (cnt != 2'b11) cnt_nxt = cnt + 2'b01;
    end else begin
      if (cnt != 2'b00) cnt_nxt = cnt - 2'b01;
    end
  end

endmodule

// File: rtl/gshare_pht.sv
// Gshare PHT: PC^GHR indexed 2-bit counters with a self-initialising sweep after reset.
// Optional same-cycle update forwarding into the prediction: define GSHARE_PHT_BYPASS_EN.
//
// state | meaning
// INIT  | sweeping init_ptr over the table writing INIT_CNT; updates dropped, prediction 0
// RUN   | normal lookup and update; terminal until reset
module gshare_pht
  import gshare_pkg::*;
#(
  parameter int       IDX_W    = PHT_IDX_W,
  parameter pht_cnt_t INIT_CNT = PHT_WNT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_pc_f,
  input  logic [IDX_W-1:0] i_ghr_f,
  output logic             o_pred_taken,
  output logic [IDX_W-1:0] o_pht_idx_f,
  input  logic             i_upd_valid,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken,
  output logic             o_init_busy
);

  localparam int DEPTH = 1 << IDX_W;

  pht_cnt_t         pht [DEPTH];
  pht_state_e       state, state_nxt;
  logic [IDX_W-1:0] init_ptr, init_ptr_nxt;
  logic [IDX_W-1:0] lookup_idx, wr_idx;
  logic             wr_en;
  pht_cnt_t         wr_data, lookup_cnt, upd_cnt, upd_nxt;
  logic             unused_pc;

  assign unused_pc   = ^{i_pc_f[31:IDX_W+2], i_pc_f[1:0]};

  assign lookup_idx  = i_pc_f[IDX_W+1:2] ^ i_ghr_f;
  assign o_pht_idx_f = lookup_idx;
  assign lookup_cnt  = pht[lookup_idx];
  assign upd_cnt     = pht[i_upd_idx];

  // One incrementer serves both the committed write and the forwarded prediction.
  sat_cnt2 u_sat_cnt2 (
    .cnt     (upd_cnt),
    .taken   (i_upd_taken),
    .cnt_nxt (upd_nxt)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state    <= state_nxt;
      init_ptr <= init_ptr_nxt;
    end
  end

  // Array has no reset so it maps onto distributed RAM; the INIT sweep fills it.
  always_ff @(posedge i_clk) begin
    if (wr_en) pht[wr_idx] <= wr_data;
  end

  always_comb begin
    state_nxt    = state;
    init_ptr_nxt = init_ptr;
    wr_en        = 1'b0;
    wr_idx       = i_upd_idx;
    wr_data      = upd_nxt;
    o_init_busy  = 1'b0;
    o_pred_taken = 1'b0;
    case (state)
      INIT: begin
        o_init_busy  = 1'b1;
        wr_en        = 1'b1;
        wr_idx       = init_ptr;
        wr_data      = INIT_CNT;
        init_ptr_nxt = init_ptr + 1'b1;
        if (&init_ptr) state_nxt = RUN;
      end
      RUN: begin
        wr_en        = i_upd_valid;
        o_pred_taken = lookup_cnt[1];
`ifdef GSHARE_PHT_BYPASS_EN
        if (i_upd_valid && (i_upd_idx == lookup_idx)) o_pred_taken = upd_nxt[1];
`endif
      end
      default: state_nxt = INIT;
    endcase
  end

endmodule

// File: tb/tb_gshare_pht.sv
// Directed self-checking bench for gshare_pht (default IDX_W=10).
module tb_gshare_pht;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_pc_f;
  logic [9:0]  i_ghr_f;
  logic        o_pred_taken;
  logic [9:0]  o_pht_idx_f;
  logic        i_upd_valid;
  logic [9:0]  i_upd_idx;
  logic        i_upd_taken;
  logic        o_init_busy;

  int checks = 0;
  int errors = 0;
  int n;

  gshare_pht dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_pc_f       (i_pc_f),
    .i_ghr_f      (i_ghr_f),
    .o_pred_taken (o_pred_taken),
    .o_pht_idx_f  (o_pht_idx_f),
    .i_upd_valid  (i_upd_valid),
    .i_upd_idx    (i_upd_idx),
    .i_upd_taken  (i_upd_taken),
    .o_init_busy  (o_init_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic look(input logic [9:0] idx);
    i_pc_f  = {20'b0, idx, 2'b00};
    i_ghr_f = '0;
    #1;
  endtask

  task automatic upd(input logic [9:0] idx, input logic taken);
    i_upd_valid = 1'b1;
    i_upd_idx   = idx;
    i_upd_taken = taken;
    tick();
    i_upd_valid = 1'b0;
    #1;
  endtask

  task automatic wait_init(inout int cnt);
    while (o_init_busy && cnt < 2000) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    i_reset = 1'b1; i_pc_f = '0; i_ghr_f = '0;
    i_upd_valid = 1'b0; i_upd_idx = '0; i_upd_taken = 1'b0;
    repeat (3) tick();
    chk("rst_busy", o_init_busy, 1);
    chk("rst_pred", o_pred_taken, 0);

    // First init; an update to entry 5 after the sweep has passed it must be dropped.
    i_reset = 1'b0;
    n = 0;
    repeat (100) begin tick(); n++; end
    chk("init_busy_mid", o_init_busy, 1);
    i_upd_valid = 1'b1; i_upd_idx = 10'h005; i_upd_taken = 1'b1;
    repeat (3) begin tick(); n++; end
    i_upd_valid = 1'b0;
    wait_init(n);
    chk("init_len", n, 1024);
    chk("run_busy", o_init_busy, 0);

    for (int i = 0; i < 1024; i++) begin
      look(i[9:0]);
      chk("scan_pred", o_pred_taken, 0);
    end

    look(10'h005);
    chk("drop_pred", o_pred_taken, 0);
    upd(10'h005, 1'b1);
    chk("drop_pred_t1", o_pred_taken, 1);

    i_pc_f = 32'h0000_0AA8; i_ghr_f = 10'h3FF; #1;
    chk("idx_hash", o_pht_idx_f, 10'h155);
    chk("pred_155_init", o_pred_taken, 0);
    upd(10'h155, 1'b1);
    chk("pred_155_t1", o_pred_taken, 1);
    upd(10'h155, 1'b1);
    chk("pred_155_t2", o_pred_taken, 1);
    upd(10'h155, 1'b1);
    chk("pred_155_t3", o_pred_taken, 1);
    upd(10'h155, 1'b0);
    chk("pred_155_n1", o_pred_taken, 1);
    upd(10'h155, 1'b0);
    chk("pred_155_n2", o_pred_taken, 0);
    look(10'h154);
    chk("pred_154", o_pred_taken, 0);
    look(10'h156);
    chk("pred_156", o_pred_taken, 0);

    look(10'h000);
    upd(10'h000, 1'b0);
    chk("pred_000_n1", o_pred_taken, 0);
    upd(10'h000, 1'b0);
    chk("pred_000_n2", o_pred_taken, 0);
    upd(10'h000, 1'b1);
    chk("pred_000_sat_t1", o_pred_taken, 0);
    upd(10'h000, 1'b1);
    chk("pred_000_sat_t2", o_pred_taken, 1);
    look(10'h001);
    chk("pred_001", o_pred_taken, 0);
    upd(10'h001, 1'b1);
    chk("pred_001_t1", o_pred_taken, 1);

    // Consecutive-cycle updates to one index: 01->10->11, then one decrement stays taken.
    look(10'h2A0);
    i_upd_valid = 1'b1; i_upd_idx = 10'h2A0; i_upd_taken = 1'b1;
    tick();
    tick();
    i_upd_valid = 1'b0; #1;
    chk("b2b_pred", o_pred_taken, 1);
    upd(10'h2A0, 1'b0);
    chk("b2b_after_dec", o_pred_taken, 1);

    look(10'h0F0);
    i_upd_valid = 1'b1; i_upd_idx = 10'h0F0; i_upd_taken = 1'b1; #1;
`ifdef GSHARE_PHT_BYPASS_EN
    chk("fwd_same_cycle", o_pred_taken, 1);
`else
    chk("fwd_same_cycle", o_pred_taken, 0);
`endif
    tick();
    i_upd_valid = 1'b0; #1;
    chk("fwd_next_cycle", o_pred_taken, 1);

    // Reset mid-RUN, then again mid-INIT at cycle 500.
    i_reset = 1'b1; #1;
    chk("rerst_busy", o_init_busy, 1);
    chk("rerst_pred", o_pred_taken, 0);
    tick();
    i_reset = 1'b0;
    repeat (500) tick();
    chk("init2_busy_500", o_init_busy, 1);
    i_reset = 1'b1; #1;
    chk("pulse_busy", o_init_busy, 1);
    tick();
    i_reset = 1'b0;
    look(10'h2A0);
    chk("init3_pred_forced", o_pred_taken, 0);
    n = 0;
    wait_init(n);
    chk("init3_len", n, 1024);
    look(10'h2A0);
    chk("reinit_2a0", o_pred_taken, 0);
    upd(10'h2A0, 1'b1);
    chk("reinit_2a0_t1", o_pred_taken, 1);
    look(10'h155);
    chk("reinit_155", o_pred_taken, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gshare_pht.md
GSHARE_PHT -- requirements
Module: gshare_pht

Interface
REQ-001 SHALL have parameter IDX_W, default 10, meaning PHT index width and GHR width (2^IDX_W entries).
REQ-002 SHALL have parameter INIT_CNT, default 2'b01, meaning counter value written during initialisation (weakly not-taken).
REQ-003 SHALL have port i_clk  input  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_pc_f  input  32  fetch-stage PC for lookup.
REQ-006 SHALL have port i_ghr_f  input  IDX_W  speculative global history presented at fetch.
REQ-007 SHALL have port o_pred_taken  output  1  taken prediction for i_pc_f.
REQ-008 SHALL have port o_pht_idx_f  output  IDX_W  lookup index, carried down the pipeline for update.
REQ-009 SHALL have port i_upd_valid  input  1  resolved conditional branch update strobe.
REQ-010 SHALL have port i_upd_idx  input  IDX_W  index captured at that branch's lookup.
REQ-011 SHALL have port i_upd_taken  input  1  resolved branch direction.
REQ-012 SHALL have port o_init_busy  output  1  high while the table is being initialised.

Function
REQ-013 SHALL compute o_pht_idx_f = i_pc_f[IDX_W+1:2] XOR i_ghr_f, combinationally.
REQ-014 SHALL drive o_pred_taken = MSB of counter[o_pht_idx_f], a combinational read with zero-cycle latency, when not initialising.
REQ-015 SHALL hold one 2-bit saturating counter per entry, with values 00 strongly NT, 01 weakly NT, 10 weakly T, 11 strongly T.
REQ-016 SHALL, on a clock edge with i_upd_valid=1 in state RUN, increment counter[i_upd_idx] when i_upd_taken=1 and decrement it otherwise.
REQ-017 SHALL saturate the counter: increment at 11 stays 11; decrement at 00 stays 00.
REQ-018 SHALL modify only entry i_upd_idx on an update; all other entries remain unchanged.
REQ-019 SHALL have init FSM states INIT and RUN. INIT: each cycle writes INIT_CNT to entry init_ptr, then increments init_ptr. Transition INIT->RUN on the cycle that writes entry 2^IDX_W-1. RUN is terminal until reset.
REQ-020 SHALL complete initialisation in exactly 2^IDX_W cycles after reset deassertion (1024 at default).
REQ-021 SHALL, in INIT, drive o_init_busy=1 and o_pred_taken=0, and silently drop i_upd_valid.
REQ-022 SHALL deassert o_init_busy in the first cycle of RUN.
REQ-023 SHALL compute the update as a read-modify-write within one cycle; back-to-back updates to the same index in consecutive cycles SHALL each take effect (no lost update).

Reset
REQ-024 SHALL, on i_reset=1, asynchronously force state=INIT, init_ptr=0, o_init_busy=1, o_pred_taken=0.
REQ-025 SHALL restart initialisation from entry 0 if reset asserts mid-INIT or mid-RUN; counter array contents need no reset.

Configuration
REQ-026 SHALL support the macro GSHARE_PHT_BYPASS_EN.
REQ-027 SHALL, with GSHARE_PHT_BYPASS_EN defined, when i_upd_valid=1 and i_upd_idx==o_pht_idx_f in RUN, derive o_pred_taken from the post-update counter value (same-cycle forwarding).
REQ-028 SHALL, without GSHARE_PHT_BYPASS_EN, derive o_pred_taken from the pre-update stored value in that case; the update still commits at the edge.

Structure
REQ-029 SHALL take from package gshare_pkg: IDX_W default, typedef pht_cnt_t (logic [1:0]), enum pht_state_e {INIT, RUN}, constant PHT_WNT=2'b01.
REQ-030 SHALL instantiate sub-module sat_cnt2 (pure combinational next-count from current count and taken), used for the update path and the bypass path.
REQ-031 SHALL keep the array as a flat register file inferable as distributed RAM: one write port, two read ports (lookup, update).

Verification
REQ-032 SHALL cover: reset then idle -> o_init_busy=1 for exactly 1024 cycles, then 0; every entry reads 01, so o_pred_taken=0.
REQ-033 SHALL cover: in RUN, idx 0x155 updated taken x3 -> counter 01->10->11->11; lookup with pc[11:2]^ghr=0x155 gives o_pred_taken=1.
REQ-034 SHALL cover: idx 0x000 at 01, updated not-taken x2 -> 00, 00 (saturation); neighbouring idx 0x001 still 01.
REQ-035 SHALL cover: pc=0x0000_0AA8, ghr=0x3FF -> o_pht_idx_f=0x2AA^0x3FF=0x155.
REQ-036 SHALL cover: same-cycle update taken and lookup of idx 0x0F0 at 01 -> o_pred_taken=1 with GSHARE_PHT_BYPASS_EN, 0 without; next cycle 1 in both builds.
REQ-037 SHALL cover: reset pulse at init cycle 500 -> init_ptr returns to 0, o_init_busy held for a full 1024 cycles after release; an update issued during INIT is dropped (entry still 01).
